// File: rtl/mcb_pkg.sv
// Shared MCB command codes, burst-length width and frame writer state encoding.
package mcb_pkg;

  localparam logic [2:0] MCB_CMD_WRITE = 3'b000;
  localparam logic [2:0] MCB_CMD_READ  = 3'b001;
  localparam int         MCB_BL_W      = 6;

  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_FILL     = 2'd1,
    ST_CMD      = 2'd2,
    ST_DRAIN    = 2'd3
  } fw_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mcb_frame_writer.sv
// Packs pixel beats into MCB write bursts and rotates across NUM_BUFS frame buffers.
// Optional build macro FW_TIMEOUT_FLUSH_EN flushes a stalled partial burst after TIMEOUT idle cycles.
module mcb_frame_writer
  import mcb_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int BURST_LEN   = 32,
  parameter int FRAME_WORDS = 8820,
  parameter int NUM_BUFS    = 2,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        calib_done,
  input  logic                        pix_valid,
  input  logic [DATA_W-1:0]           pix_data,
  input  logic                        pix_last,
  output logic                        pix_ready,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W/8-1:0]         wr_mask,
  input  logic                        wr_full,
  input  logic                        wr_empty,
  output logic                        cmd_en,
  output logic [2:0]                  cmd_instr,
  output logic [MCB_BL_W-1:0]         cmd_bl,
  output logic [29:0]                 cmd_byte_addr,
  input  logic                        cmd_full,
  output logic [$clog2(NUM_BUFS)-1:0] front_buf,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int BUF_W  = $clog2(NUM_BUFS);
  localparam int CNT_W  = 7;
  localparam int FCNT_W = $clog2(FRAME_WORDS + 1);

  localparam logic [CNT_W-1:0]  BL_C          = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FW_C          = FCNT_W'(FRAME_WORDS);
  localparam logic [FCNT_W-1:0] FCNT_ONE      = FCNT_W'(1);
  localparam logic [BUF_W-1:0]  LAST_BUF      = BUF_W'(NUM_BUFS - 1);
  localparam logic [BUF_W-1:0]  BUF_ONE       = BUF_W'(1);
  localparam logic [29:0]       BYTES_C       = 30'(DATA_W / 8);
  localparam logic [29:0]       FRAME_BYTES_C = 30'(FRAME_WORDS * (DATA_W / 8));
  localparam logic [29:0]       BASE_C        = 30'(BASE_ADDR);

  fw_state_e           state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [29:0]         ptr_q, ptr_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [BUF_W-1:0]    front_buf_q, front_buf_d;
  logic                frame_done_q, frame_done_d;
  logic                ovf_q, ovf_d;
  logic                last_q, last_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                pix_ready_c;
  logic                cmd_en_c;
  logic                close_c;
  logic [BUF_W-1:0]    buf_next;
  logic                cal_sync;

`ifdef FW_TIMEOUT_FLUSH_EN
  localparam int             TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  sync_2ff u_cal_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (calib_done),
    .q      (cal_sync)
  );

  assign buf_next = (buf_q == LAST_BUF) ? '0 : buf_q + BUF_ONE;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_cnt_d  = frame_cnt_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    front_buf_d  = front_buf_q;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q;
    last_d       = last_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    pix_ready_c  = 1'b0;
    cmd_en_c     = 1'b0;
    close_c      = 1'b0;
`ifdef FW_TIMEOUT_FLUSH_EN
    idle_d       = '0;
`endif
    unique case (state_q)
      ST_WAIT_CAL: begin
        if (cal_sync) state_d = ST_FILL;
      end
      ST_FILL: begin
        pix_ready_c = !wr_full && (count_q < BL_C);
        if (pix_valid && pix_ready_c) begin
          last_d = pix_last;
          // Beats beyond the frame size are swallowed so the source never stalls.
          if (frame_cnt_q < FW_C) begin
            wr_en_d     = 1'b1;
            wr_data_d   = pix_data;
            count_d     = count_q + CNT_ONE;
            frame_cnt_d = frame_cnt_q + FCNT_ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (pix_last || (count_d == BL_C)) state_d = ST_CMD;
        end
`ifdef FW_TIMEOUT_FLUSH_EN
        else if (count_q != '0) begin
          if (idle_q == TO_LAST) state_d = ST_CMD;
          else                   idle_d  = idle_q + TO_ONE;
        end
`endif
      end
      ST_CMD: begin
        // An empty burst only arises when pix_last landed on an overflow beat.
        if (count_q == '0) begin
          close_c = 1'b1;
        end else if (!wr_en_q && !cmd_full) begin
          cmd_en_c = 1'b1;
          close_c  = 1'b1;
        end
        if (close_c) begin
          state_d = ST_DRAIN;
          count_d = '0;
          ptr_d   = ptr_q + 30'(count_q) * BYTES_C;
          if (last_q) begin
            front_buf_d  = buf_q;
            frame_done_d = 1'b1;
            buf_d        = buf_next;
            ptr_d        = BASE_C + 30'(buf_next) * FRAME_BYTES_C;
            frame_cnt_d  = '0;
            last_d       = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (wr_empty) state_d = ST_FILL;
      end
      default: state_d = ST_WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_WAIT_CAL;
      count_q      <= '0;
      frame_cnt_q  <= '0;
      ptr_q        <= BASE_C;
      buf_q        <= '0;
      front_buf_q  <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      last_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
`ifdef FW_TIMEOUT_FLUSH_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_cnt_q  <= frame_cnt_d;
      ptr_q        <= ptr_d;
      buf_q        <= buf_d;
      front_buf_q  <= front_buf_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
`ifdef FW_TIMEOUT_FLUSH_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign pix_ready     = pix_ready_c;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign wr_mask       = '0;
  assign cmd_en        = cmd_en_c;
  assign cmd_instr     = MCB_CMD_WRITE;
  assign cmd_bl        = cmd_en_c ? MCB_BL_W'(count_q - CNT_ONE) : '0;
  assign cmd_byte_addr = cmd_en_c ? ptr_q : '0;
  assign front_buf     = front_buf_q;
  assign frame_done    = frame_done_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_mcb_frame_writer.sv
// Randomised self-checking bench for mcb_frame_writer with a transaction-level frame/burst model.
module tb_mcb_frame_writer;

  localparam int DATA_W      = 64;
  localparam int BURST_LEN   = 32;
  localparam int FRAME_WORDS = 8820;
  localparam int NUM_BUFS    = 3;
  localparam int BASE_ADDR   = 0;
  localparam int TIMEOUT     = 64;
  localparam int BYTES       = DATA_W / 8;

  logic              clk = 1'b0;
  logic              nreset;
  logic              calib_done;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_last;
  logic              pix_ready;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_mask;
  logic              wr_full;
  logic              wr_empty;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [29:0]       cmd_byte_addr;
  logic              cmd_full;
  logic [1:0]        front_buf;
  logic              frame_done;
  logic              overflow;

  mcb_frame_writer #(
    .DATA_W      (DATA_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .NUM_BUFS    (NUM_BUFS),
    .BASE_ADDR   (BASE_ADDR),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .calib_done    (calib_done),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_last      (pix_last),
    .pix_ready     (pix_ready),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .wr_full       (wr_full),
    .wr_empty      (wr_empty),
    .cmd_en        (cmd_en),
    .cmd_instr     (cmd_instr),
    .cmd_bl        (cmd_bl),
    .cmd_byte_addr (cmd_byte_addr),
    .cmd_full      (cmd_full),
    .front_buf     (front_buf),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Comparison helper used by every check in the bench
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: DUT event with nothing expected at %0t", name, $time);
  endtask

  // Reference model: what the MCB port must see, derived from accepted beats
  typedef struct {
    int     bl;
    longint addr;
    int     words;
  } cmd_t;

  logic [DATA_W-1:0] dataQ[$];
  cmd_t              cmdQ[$];
  int                frontQ[$];
  int                logBl[$];
  longint            logAddr[$];
  int                frontLog[$];

  int     mCount       = 0;
  int     mFrameWords  = 0;
  int     mBuf         = 0;
  int     mIdle        = 0;
  int     wordsWritten = 0;
  longint mPtr         = BASE_ADDR;
  bit     mOvf         = 1'b0;
  int     wrSeen       = 0;
  bit     monOn        = 1'b0;

  function automatic void closeBurst(input bit swap);
    cmd_t c;
    if (mCount > 0) begin
      c.bl    = mCount - 1;
      c.addr  = mPtr;
      c.words = wordsWritten;
      cmdQ.push_back(c);
      mPtr = mPtr + mCount * BYTES;
    end
    mCount = 0;
    mIdle  = 0;
    if (swap) begin
      frontQ.push_back(mBuf);
      mBuf        = (mBuf + 1) % NUM_BUFS;
      mPtr        = BASE_ADDR + longint'(mBuf) * FRAME_WORDS * BYTES;
      mFrameWords = 0;
    end
  endfunction

  // Compare DUT outputs each cycle, then fold the beat about to be captured into the model
  always @(negedge clk) begin
    if (monOn) begin
      if (cmd_en) begin
        logBl.push_back(int'(cmd_bl));
        logAddr.push_back(longint'(cmd_byte_addr));
        checkOutput("cmd_en_while_cmd_full", cmd_full, 0);
        checkOutput("cmd_instr", cmd_instr, 3'b000);
        if (cmdQ.size() == 0) reportUnexpected("unexpected_cmd");
        else begin
          cmd_t c;
          c = cmdQ.pop_front();
          checkOutput("cmd_bl", cmd_bl, c.bl);
          checkOutput("cmd_byte_addr", cmd_byte_addr, c.addr);
          checkOutput("cmd_after_all_data", wrSeen, c.words);
        end
      end
      if (wr_en) begin
        wrSeen++;
        checkOutput("wr_mask", wr_mask, 0);
        if (dataQ.size() == 0) reportUnexpected("unexpected_wr_en");
        else checkOutput("wr_data", wr_data, dataQ.pop_front());
      end
      if (frame_done) begin
        frontLog.push_back(int'(front_buf));
        if (frontQ.size() == 0) reportUnexpected("unexpected_frame_done");
        else checkOutput("front_buf", front_buf, frontQ.pop_front());
      end
      checkOutput("overflow", overflow, mOvf);
      if (wr_full) checkOutput("pix_ready_while_wr_full", pix_ready, 0);

      if (pix_valid && pix_ready) begin
        if (mFrameWords < FRAME_WORDS) begin
          dataQ.push_back(pix_data);
          mFrameWords++;
          mCount++;
          wordsWritten++;
        end else begin
          mOvf = 1'b1;
        end
        mIdle = 0;
        if (mCount == BURST_LEN || pix_last) closeBurst(pix_last);
      end else if (mCount > 0) begin
        mIdle++;
`ifdef FW_TIMEOUT_FLUSH_EN
        if (mIdle == TIMEOUT) closeBurst(1'b0);
`endif
      end
    end
  end

  // MCB side flow control, randomised unless the sequence wants it quiet
  bit envOn    = 1'b0;
  bit holdFull = 1'b0;

  initial begin
    wr_full  = 1'b0;
    cmd_full = 1'b0;
    wr_empty = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!envOn) begin
        wr_full  = holdFull;
        cmd_full = 1'b0;
        wr_empty = 1'b1;
      end else begin
        wr_full  = holdFull || ($urandom_range(99) < 10);
        cmd_full = ($urandom_range(99) < 25);
        wr_empty = ($urandom_range(99) < 70);
      end
    end
  end

  int cycles = 0;
  always @(posedge clk) begin
    cycles++;
    if (cycles > 95000) begin
      $display("[TB] FAIL watchdog: cycle %0d exceeded budget of 95000", cycles);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  // Offer n beats with random gaps; optionally tag the final accepted beat as pix_last
  task automatic applyStimulus(input int n, input bit lastAtEnd, input int validPct);
    int i;
    i = 0;
    while (i < n) begin
      @(posedge clk);
      #2;
      pix_valid = ($urandom_range(99) < validPct);
      pix_data  = {$urandom(), $urandom()};
      pix_last  = lastAtEnd && (i == n - 1);
      @(negedge clk);
      if (pix_valid && pix_ready) i++;
    end
    @(posedge clk);
    #2;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  function automatic longint addrAt(input int idx);
    return (idx < logAddr.size()) ? logAddr[idx] : -1;
  endfunction

  function automatic int blAt(input int idx);
    return (idx < logBl.size()) ? logBl[idx] : -1;
  endfunction

  function automatic int frontAt(input int idx);
    return (idx < frontLog.size()) ? frontLog[idx] : -1;
  endfunction

  initial begin
    int quietViol;
    int readySeen;
    int waitCnt;

    nreset     = 1'b0;
    calib_done = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    pix_last   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_pix_ready", pix_ready, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_cmd_en", cmd_en, 0);
    checkOutput("reset_cmd_bl", cmd_bl, 0);
    checkOutput("reset_cmd_addr", cmd_byte_addr, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_front_buf", front_buf, 0);
    checkOutput("reset_overflow", overflow, 0);

    @(posedge clk);
    #2;
    nreset = 1'b1;
    monOn  = 1'b1;

    // No activity while calibration is pending
    quietViol = 0;
    repeat (100) begin
      @(negedge clk);
      if (pix_ready || wr_en || cmd_en) quietViol++;
    end
    checkOutput("quiet_before_calib", quietViol, 0);

    @(posedge clk);
    #2;
    calib_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ready_low_2cyc_after_calib", pix_ready, 0);
    waitCnt = 0;
    while (!pix_ready && waitCnt < 5) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("ready_after_calib", pix_ready, 1);

    // Frame 0: two clean bursts, then randomised traffic
    applyStimulus(64, 1'b0, 100);
    envOn = 1'b1;
    applyStimulus(FRAME_WORDS - 64, 1'b1, 85);

    // Frame 1 with a ten-cycle write FIFO full stall in the middle of a burst
    applyStimulus(4010, 1'b0, 85);
    envOn    = 1'b0;
    holdFull = 1'b1;
    readySeen = 0;
    repeat (10) begin
      @(posedge clk);
      #2;
      pix_valid = 1'b1;
      pix_data  = {$urandom(), $urandom()};
      @(negedge clk);
      if (pix_ready) readySeen++;
    end
    pix_valid = 1'b0;
    holdFull  = 1'b0;
    checkOutput("no_ready_during_full_hold", readySeen, 0);
    envOn = 1'b1;
    applyStimulus(FRAME_WORDS - 4010, 1'b1, 85);

    // Frame 2 overruns its buffer by ten beats
    applyStimulus(FRAME_WORDS + 10, 1'b1, 85);
    checkOutput("overflow_sticky", overflow, 1);

    // Frame 3: a short partial burst followed by a long idle stretch
    envOn = 1'b0;
    repeat (20) @(posedge clk);
    applyStimulus(5, 1'b0, 100);
    repeat (80) @(posedge clk);
    @(negedge clk);
`ifdef FW_TIMEOUT_FLUSH_EN
    checkOutput("timeout_cmd_count", logBl.size(), 829);
    checkOutput("timeout_cmd_bl", blAt(828), 4);
    checkOutput("timeout_no_frame_done", frontLog.size(), 3);
`else
    checkOutput("no_flush_without_timeout", logBl.size(), 828);
`endif
    envOn = 1'b1;
    applyStimulus(40, 1'b1, 85);

    waitCnt = 0;
    while ((dataQ.size() != 0 || cmdQ.size() != 0 || frontQ.size() != 0) && waitCnt < 500) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("data_queue_drained", dataQ.size(), 0);
    checkOutput("cmd_queue_drained", cmdQ.size(), 0);
    checkOutput("frame_queue_drained", frontQ.size(), 0);

    // Hand-computed anchors for the model
    checkOutput("first_cmd_bl", blAt(0), 31);
    checkOutput("first_cmd_addr", addrAt(0), 0);
    checkOutput("second_cmd_addr", addrAt(1), 256);
    checkOutput("frame0_last_bl", blAt(275), 19);
    checkOutput("frame0_last_addr", addrAt(275), 70400);
    checkOutput("frame1_first_addr", addrAt(276), 70560);
    checkOutput("frame2_first_addr", addrAt(552), 141120);
    checkOutput("frame3_first_addr", addrAt(828), 0);
    checkOutput("front_seq0", frontAt(0), 0);
    checkOutput("front_seq1", frontAt(1), 1);
    checkOutput("front_seq2", frontAt(2), 2);
    checkOutput("front_seq3", frontAt(3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
